upsizer_stream_arbiter: RTL

- Packet-level round-robin arbiter that shares one narrow-stream upsizer input between N_SRC independent narrow stream sources.
- Locks the grant from the first beat of a packet until its last beat is accepted, so upsizer word packing never mixes sources.
- Drives the upsizer slave port through a single registered output stage.
- Sits directly upstream of the upsizer in the interconnect.

---
 rtl/upsizer_pkg.sv | 20 ++
 rtl/upsizer_stream_arbiter_rr_pick.sv | 35 +++
 rtl/upsizer_stream_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/upsizer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | upsizer_pkg                                                                |
// | Shared arbiter FSM encoding and index-width helper.                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package upsizer_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Keeps a one-bit index even when there is a single source.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/upsizer_stream_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_pick                                                                    |
// | Combinational rotate-priority pick: first set req bit at or above ptr.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_pick #(
    parameter int N_SRC = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_SRC - 1);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        idx    = '0;
        any    = 1'b0;
        w_cand = ptr;
        for (int i = 0; i < N_SRC; i++) begin
            if (!any && req[w_cand]) begin
                any = 1'b1;
                idx = w_cand;
            end
            w_cand = (w_cand == c_LAST_IDX) ? '0 : w_cand + IDX_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/upsizer_stream_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | upsizer_stream_arbiter                                                     |
// | Packet-locked round-robin arbiter feeding one upsizer through a register.  |
// | Optional grant timeout: define UPSIZER_ARB_TIMEOUT_EN.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module upsizer_stream_arbiter
    import upsizer_pkg::*;
#(
    parameter int T_DATA_WIDTH = 4,
    parameter int N_SRC        = 4,
`ifdef UPSIZER_ARB_TIMEOUT_EN
    parameter int TIMEOUT_CYC  = 16,
`endif
    localparam int IDX_W       = clog2_min1(N_SRC)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_SRC-1:0][T_DATA_WIDTH-1:0]  s_data_i,
    input  logic [N_SRC-1:0]                    s_valid_i,
    input  logic [N_SRC-1:0]                    s_last_i,
    output logic [N_SRC-1:0]                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0]             m_data_o,
    output logic                                m_last_o,
    output logic                                m_valid_o,
    input  logic                                m_ready_i,
`ifdef UPSIZER_ARB_TIMEOUT_EN
    output logic                                timeout_o,
`endif
    output logic                                busy_o,
    output logic [IDX_W-1:0]                    gnt_idx_o
);

    localparam logic [0:0]       c_ST_IDLE  = 1'(IDLE);
    localparam logic [0:0]       c_ST_BUSY  = 1'(BUSY);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_SRC - 1);

    logic [0:0]              r_state;
    logic [IDX_W-1:0]        r_rr_ptr;
    logic [IDX_W-1:0]        r_gnt;
    logic [T_DATA_WIDTH-1:0] r_data;
    logic                    r_valid;
    logic                    r_last;

    logic                    w_busy;
    logic                    w_out_free;
    logic                    w_accept;
    logic                    w_end_pkt;
    logic                    w_any;
    logic                    w_tmo_hit;
    logic                    w_tmo_fire;
    logic [IDX_W-1:0]        w_pick;
    logic [IDX_W-1:0]        w_next_ptr;
    logic [N_SRC-1:0]        w_ready;

    rr_pick #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req (s_valid_i),
        .ptr (r_rr_ptr),
        .idx (w_pick),
        .any (w_any)
    );

    assign w_busy     = (r_state == c_ST_BUSY);
    assign w_out_free = !r_valid || m_ready_i;
    assign w_next_ptr = (r_gnt == c_LAST_IDX) ? '0 : r_gnt + IDX_W'(1);
    assign w_accept   = w_busy && w_out_free && !w_tmo_hit && s_valid_i[r_gnt];
    assign w_end_pkt  = (w_accept && s_last_i[r_gnt]) || w_tmo_fire;

`ifdef UPSIZER_ARB_TIMEOUT_EN
    localparam int             TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] c_TMO = TMO_W'(TIMEOUT_CYC);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_timeout;

    // Once the limit is hit the source is no longer offered ready; the
    // synthetic last beat waits only for the output register to free up.
    assign w_tmo_hit  = w_busy && (r_tmo_cnt == c_TMO);
    assign w_tmo_fire = w_tmo_hit && w_out_free;
    assign timeout_o  = r_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_tmo_fire;
            if (!w_busy || w_accept || w_tmo_fire) begin
                r_tmo_cnt <= '0;
            end else if (!s_valid_i[r_gnt] && !w_tmo_hit) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end
        end
    end
`else
    assign w_tmo_hit  = 1'b0;
    assign w_tmo_fire = 1'b0;
`endif

    always_comb begin
        w_ready = '0;
        if (w_busy && w_out_free && !w_tmo_hit) begin
            w_ready[r_gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_rr_ptr <= '0;
            r_gnt    <= '0;
        end else if (w_busy) begin
            if (w_end_pkt) begin
                r_state  <= c_ST_IDLE;
                r_rr_ptr <= w_next_ptr;
            end
        end else if (w_any) begin
            r_gnt   <= w_pick;
            r_state <= c_ST_BUSY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= s_data_i[r_gnt];
            r_last  <= s_last_i[r_gnt];
        end else if (w_tmo_fire) begin
            r_valid <= 1'b1;
            r_data  <= '0;
            r_last  <= 1'b1;
        end else if (m_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign s_ready_o = w_ready;
    assign m_data_o  = r_data;
    assign m_last_o  = r_last;
    assign m_valid_o = r_valid;
    assign busy_o    = w_busy;
    assign gnt_idx_o = r_gnt;

endmodule
`default_nettype wire
